// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - stopwatch mode FSM and mm:ss sequencer driven by divider square-wave edges
// Optional lap-hold feature enabled by defining STOPWATCH_LAP_EN.
module stopwatch_ctrl #(
    parameter int SEC_MAX = 59,
    parameter int MIN_MAX = 59,
    parameter int W       = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clk_1hz,
    input  logic         clk_2hz,
    input  logic         clk_blink,
    input  logic         btn_pause,
    input  logic         btn_lap,
    input  logic         sw_adj,
    input  logic         sw_sel,
    output logic [W-1:0] disp_min,
    output logic [W-1:0] disp_sec,
    output logic         running,
    output logic         in_adjust,
    output logic         blank_min,
    output logic         blank_sec,
    output logic         lap_active
);

    typedef enum logic [1:0] {
        PAUSED = 2'd0,
        RUN    = 2'd1,
        ADJUST = 2'd2
    } state_t;

    state_t       state;
    logic         resume_run;
    logic [W-1:0] min_cnt;
    logic [W-1:0] sec_cnt;
    logic         prev_1hz;
    logic         prev_2hz;
    logic         e1;
    logic         e2;
    logic         sec_at_max;
    logic         min_at_max;
    logic [W-1:0] show_min;
    logic [W-1:0] show_sec;

`ifdef STOPWATCH_LAP_EN
    logic         lap_q;
    logic [W-1:0] lap_min;
    logic [W-1:0] lap_sec;
`endif

    assign e1         = clk_1hz & ~prev_1hz;
    assign e2         = clk_2hz & ~prev_2hz;
    assign sec_at_max = (sec_cnt == W'(SEC_MAX));
    assign min_at_max = (min_cnt == W'(MIN_MAX));

`ifdef STOPWATCH_LAP_EN
    assign show_min = lap_q ? lap_min : min_cnt;
    assign show_sec = lap_q ? lap_sec : sec_cnt;
`else
    assign show_min = min_cnt;
    assign show_sec = sec_cnt;
`endif

    always_ff @(posedge clk) begin
        // Edge-detect history tracks the inputs even in reset, so a level
        // already high at release never looks like a fresh rise.
        prev_1hz <= clk_1hz;
        prev_2hz <= clk_2hz;

        if (rst) begin
            state      <= PAUSED;
            resume_run <= 1'b0;
            min_cnt    <= '0;
            sec_cnt    <= '0;
            disp_min   <= '0;
            disp_sec   <= '0;
            running    <= 1'b0;
            in_adjust  <= 1'b0;
            blank_min  <= 1'b0;
            blank_sec  <= 1'b0;
            lap_active <= 1'b0;
`ifdef STOPWATCH_LAP_EN
            lap_q      <= 1'b0;
            lap_min    <= '0;
            lap_sec    <= '0;
`endif
        end else begin
            disp_min  <= show_min;
            disp_sec  <= show_sec;
            running   <= (state == RUN);
            in_adjust <= (state == ADJUST);
            blank_min <= (state == ADJUST) && !sw_sel && clk_blink;
            blank_sec <= (state == ADJUST) && sw_sel && clk_blink;

            case (state)
                RUN: begin
                    if (e1) begin
                        if (sec_at_max) begin
                            sec_cnt <= '0;
                            min_cnt <= min_at_max ? '0 : min_cnt + 1'b1;
                        end else begin
                            sec_cnt <= sec_cnt + 1'b1;
                        end
                    end
                end
                ADJUST: begin
                    if (e2) begin
                        if (sw_sel)
                            sec_cnt <= sec_at_max ? '0 : sec_cnt + 1'b1;
                        else
                            min_cnt <= min_at_max ? '0 : min_cnt + 1'b1;
                    end
                end
                default: ;
            endcase

            case (state)
                PAUSED: begin
                    if (sw_adj) begin
                        resume_run <= 1'b0;
                        state      <= ADJUST;
                    end else if (btn_pause) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (sw_adj) begin
                        resume_run <= 1'b1;
                        state      <= ADJUST;
                    end else if (btn_pause) begin
                        state <= PAUSED;
                    end
                end
                ADJUST: begin
                    if (!sw_adj)
                        state <= resume_run ? RUN : PAUSED;
                end
                default: state <= PAUSED;
            endcase

`ifdef STOPWATCH_LAP_EN
            if (state != ADJUST && sw_adj) begin
                lap_q <= 1'b0;
            end else if (btn_lap) begin
                if (lap_q) begin
                    lap_q <= 1'b0;
                end else if (state == RUN) begin
                    lap_q   <= 1'b1;
                    lap_min <= min_cnt;
                    lap_sec <= sec_cnt;
                end
            end
            lap_active <= lap_q;
`else
            // btn_lap has no function without the lap feature.
            lap_active <= btn_lap & 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - self-checking bench for stopwatch_ctrl (table, directed and random vs model)
module tb_stopwatch_ctrl;

`ifdef STOPWATCH_LAP_EN
    localparam bit LAP_EN = 1'b1;
`else
    localparam bit LAP_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clk_1hz = 1'b0, clk_2hz = 1'b0, clk_blink = 1'b0;
    logic       btn_pause = 1'b0, btn_lap = 1'b0, sw_adj = 1'b0, sw_sel = 1'b0;
    logic [5:0] disp_min, disp_sec;
    logic       running, in_adjust, blank_min, blank_sec, lap_active;

    always #5 clk = ~clk;

    stopwatch_ctrl dut (
        .clk(clk), .rst(rst), .clk_1hz(clk_1hz), .clk_2hz(clk_2hz), .clk_blink(clk_blink),
        .btn_pause(btn_pause), .btn_lap(btn_lap), .sw_adj(sw_adj), .sw_sel(sw_sel),
        .disp_min(disp_min), .disp_sec(disp_sec), .running(running), .in_adjust(in_adjust),
        .blank_min(blank_min), .blank_sec(blank_sec), .lap_active(lap_active)
    );

    int checks = 0;
    int passed = 0;

    // Reference: elapsed time as total seconds, mode as 0=paused 1=run 2=adjust
    int m_total = 0, m_state = 0, m_lap_total = 0;
    bit m_resume = 0, m_lap = 0, m_p1 = 0, m_p2 = 0;
    int o_min = 0, o_sec = 0;
    bit o_run = 0, o_adj = 0, o_bmin = 0, o_bsec = 0, o_lap = 0;

    typedef struct {
        bit rst;
        bit c1;
        bit bp;
        int emin;
        int esec;
        bit erun;
    } vec_t;

    task automatic check(string name, int act, int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic model_step();
        int shown, old_total, old_state;
        bit r1, r2;
        if (rst) begin
            m_state = 0; m_total = 0; m_resume = 0; m_lap = 0; m_lap_total = 0;
            o_min = 0; o_sec = 0; o_run = 0; o_adj = 0; o_bmin = 0; o_bsec = 0; o_lap = 0;
        end else begin
            shown  = m_lap ? m_lap_total : m_total;
            o_min  = shown / 60;
            o_sec  = shown % 60;
            o_run  = (m_state == 1);
            o_adj  = (m_state == 2);
            o_bmin = o_adj && !sw_sel && clk_blink;
            o_bsec = o_adj && sw_sel && clk_blink;
            o_lap  = m_lap;
            r1 = clk_1hz && !m_p1;
            r2 = clk_2hz && !m_p2;
            old_total = m_total;
            old_state = m_state;
            if (old_state == 1 && r1)
                m_total = (old_total + 1) % 3600;
            else if (old_state == 2 && r2) begin
                if (sw_sel) m_total = (old_total / 60) * 60 + (old_total % 60 + 1) % 60;
                else        m_total = ((old_total / 60 + 1) % 60) * 60 + old_total % 60;
            end
            if (LAP_EN) begin
                if (old_state != 2 && sw_adj) m_lap = 0;
                else if (btn_lap) begin
                    if (m_lap) m_lap = 0;
                    else if (old_state == 1) begin
                        m_lap = 1;
                        m_lap_total = old_total;
                    end
                end
            end
            if (old_state != 2 && sw_adj) begin
                m_resume = (old_state == 1);
                m_state  = 2;
            end else if (old_state == 2 && !sw_adj)
                m_state = m_resume ? 1 : 0;
            else if (old_state != 2 && btn_pause)
                m_state = 1 - old_state;
        end
        m_p1 = clk_1hz;
        m_p2 = clk_2hz;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("m_disp_min", disp_min, o_min);
        check("m_disp_sec", disp_sec, o_sec);
        check("m_running", running, o_run);
        check("m_in_adjust", in_adjust, o_adj);
        check("m_blank_min", blank_min, o_bmin);
        check("m_blank_sec", blank_sec, o_bsec);
        check("m_lap_active", lap_active, o_lap);
        btn_pause = 1'b0;
        btn_lap   = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clk_1hz = 0; clk_2hz = 0; clk_blink = 0; sw_adj = 0; sw_sel = 0;
        tick(); tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic rise1();
        clk_1hz = 1'b1; tick(); tick();
        clk_1hz = 1'b0; tick(); tick();
    endtask

    task automatic rise2();
        clk_2hz = 1'b1; tick(); tick();
        clk_2hz = 1'b0; tick(); tick();
    endtask

    vec_t vecs[18];

    initial begin
        vecs[0]  = '{1, 0, 0, 0, 0, 0};
        vecs[1]  = '{1, 1, 0, 0, 0, 0};
        vecs[2]  = '{0, 1, 0, 0, 0, 0};
        vecs[3]  = '{0, 0, 0, 0, 0, 0};
        vecs[4]  = '{0, 1, 0, 0, 0, 0};
        vecs[5]  = '{0, 0, 0, 0, 0, 0};
        vecs[6]  = '{0, 1, 0, 0, 0, 0};
        vecs[7]  = '{0, 0, 0, 0, 0, 0};
        vecs[8]  = '{0, 1, 0, 0, 0, 0};
        vecs[9]  = '{0, 0, 1, 0, 0, 0};
        vecs[10] = '{0, 0, 0, 0, 0, 1};
        vecs[11] = '{0, 1, 0, 0, 0, 1};
        vecs[12] = '{0, 1, 0, 0, 1, 1};
        vecs[13] = '{0, 0, 0, 0, 1, 1};
        vecs[14] = '{0, 1, 1, 0, 1, 1};
        vecs[15] = '{0, 1, 0, 0, 2, 0};
        vecs[16] = '{0, 0, 0, 0, 2, 0};
        vecs[17] = '{0, 1, 0, 0, 2, 0};

        // Paused ignores ticks, high-at-release is not an edge, pause+tick applies tick
        for (int i = 0; i < 18; i++) begin
            rst = vecs[i].rst;
            clk_1hz = vecs[i].c1;
            btn_pause = vecs[i].bp;
            tick();
            check($sformatf("tbl%0d_min", i), disp_min, vecs[i].emin);
            check($sformatf("tbl%0d_sec", i), disp_sec, vecs[i].esec);
            check($sformatf("tbl%0d_run", i), running, vecs[i].erun);
        end

        // 61 rises from 00:00 in RUN, with first-update latency
        do_reset();
        btn_pause = 1'b1; tick(); tick();
        clk_1hz = 1'b1; tick();
        check("lat_cycle1", disp_sec, 0);
        tick();
        check("lat_cycle2", disp_sec, 1);
        clk_1hz = 1'b0; tick(); tick();
        for (int i = 0; i < 60; i++) rise1();
        check("run61_min", disp_min, 1);
        check("run61_sec", disp_sec, 1);
        check("run61_running", running, 1);

        // Preload 59:58 via ADJUST, then wrap through 59:59 to 00:00
        do_reset();
        btn_pause = 1'b1; tick();
        sw_adj = 1'b1; sw_sel = 1'b0; tick(); tick();
        for (int i = 0; i < 59; i++) rise2();
        sw_sel = 1'b1; tick();
        for (int i = 0; i < 58; i++) rise2();
        sw_adj = 1'b0; tick(); tick(); tick();
        check("pre_min", disp_min, 59);
        check("pre_sec", disp_sec, 58);
        check("pre_running", running, 1);
        rise1();
        check("w1_min", disp_min, 59);
        check("w1_sec", disp_sec, 59);
        rise1();
        check("w2_min", disp_min, 0);
        check("w2_sec", disp_sec, 0);

        // Seconds adjust wraps without carry, blanking follows clk_blink
        do_reset();
        btn_pause = 1'b1; tick();
        for (int i = 0; i < 10; i++) rise1();
        check("adj_start_sec", disp_sec, 10);
        sw_adj = 1'b1; sw_sel = 1'b1; tick(); tick();
        for (int i = 0; i < 55; i++) rise2();
        check("adj_sec", disp_sec, 5);
        check("adj_min", disp_min, 0);
        check("adj_flag", in_adjust, 1);
        rise1();
        check("adj_e1_ignored", disp_sec, 5);
        clk_blink = 1'b1; tick(); tick();
        check("blank_sec_hi", blank_sec, 1);
        check("blank_min_lo", blank_min, 0);
        sw_sel = 1'b0; tick(); tick();
        check("blank_min_hi", blank_min, 1);
        check("blank_sec_lo", blank_sec, 0);
        clk_blink = 1'b0; tick();
        check("blank_min_off", blank_min, 0);
        sw_adj = 1'b0; tick(); tick();
        check("resume_run", running, 1);
        check("resume_adj", in_adjust, 0);
        check("resume_blank", blank_sec, 0);

        // Lap hold
        do_reset();
        btn_pause = 1'b1; tick();
        for (int i = 0; i < 5; i++) rise1();
        btn_lap = 1'b1; tick();
        for (int i = 0; i < 5; i++) rise1();
`ifdef STOPWATCH_LAP_EN
        check("lap_hold_sec", disp_sec, 5);
        check("lap_hold_flag", lap_active, 1);
        btn_lap = 1'b1; tick(); tick();
        check("lap_rel_sec", disp_sec, 10);
        check("lap_rel_flag", lap_active, 0);
`else
        check("nolap_sec", disp_sec, 10);
        check("nolap_flag", lap_active, 0);
`endif

        // Random stimulus against the reference model
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 9) == 0) clk_1hz = ~clk_1hz;
            if ($urandom_range(0, 5) == 0) clk_2hz = ~clk_2hz;
            if ($urandom_range(0, 3) == 0) clk_blink = ~clk_blink;
            btn_pause = ($urandom_range(0, 39) == 0);
            btn_lap   = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 149) == 0) sw_adj = ~sw_adj;
            if ($urandom_range(0, 49) == 0) sw_sel = ~sw_sel;
            rst = ($urandom_range(0, 999) == 0);
            tick();
        end
        rst = 1'b0;

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
